xadc_reader: RTL and testbench
==============================

XADC_READER -- requirements
Module: xadc_reader

Interface
REQ-001 Parameter CONVST_CLKS, default 4: width of the CONVST pulse, in Clk cycles; legal range 1..15.
REQ-002 Parameter TIMEOUT_CLKS, default 2000: maximum wait for EOC or DRDY, in Clk cycles (20us at 100MHz).
REQ-003 Clk  input  1  100MHz system clock; all logic is rising-edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Trigger  input  1  single-cycle conversion request from the 100us pulse timer.
REQ-006 EOC  input  1  XADC end-of-conversion, single-cycle.
REQ-007 Channel  input  5  XADC channel number, valid while EOC is high.
REQ-008 DRDY  input  1  XADC DRP read-data-ready, single-cycle.
REQ-009 DO  input  16  XADC DRP read data, valid while DRDY is high.
REQ-010 CONVST  output  1  XADC conversion start.
REQ-011 DEN  output  1  DRP enable, single-cycle.
REQ-012 DWE  output  1  DRP write enable, tied to 0.
REQ-013 DADDR  output  7  DRP address.
REQ-014 Sample  output  12  last converted result.
REQ-015 SampleChan  output  5  channel of Sample.
REQ-016 SampleValid  output  1  single-cycle strobe: Sample and SampleChan are new.
REQ-017 Overrun  output  1  single-cycle strobe: Trigger was dropped.
REQ-018 Timeout  output  1  single-cycle strobe: a conversion was abandoned.

Function
REQ-019 FSM states: IDLE, CONVERT, WAIT_EOC, READ, WAIT_DRDY, DONE.
REQ-020 IDLE: Trigger=1 -> CONVERT next cycle; otherwise remain in IDLE.
REQ-021 CONVST is registered and is high for exactly CONVST_CLKS cycles, starting the cycle after Trigger is accepted; the FSM then moves to WAIT_EOC.
REQ-022 WAIT_EOC: EOC=1 -> capture DADDR={2'b00,Channel} and move to READ.
REQ-023 READ: DEN=1 for exactly one cycle with DADDR stable; then move to WAIT_DRDY.
REQ-024 WAIT_DRDY: DRDY=1 -> Sample<=DO[15:4], SampleChan<=DADDR[4:0]; move to DONE.
REQ-025 DONE: SampleValid=1 for one cycle; move to IDLE. Latency from Trigger to SampleValid is CONVST_CLKS + EOC wait + DRDY wait + 3 cycles.
REQ-026 Timeout counter: cleared on entry to WAIT_EOC and on entry to WAIT_DRDY.
REQ-027 Timeout counter: increments every cycle in WAIT_EOC and WAIT_DRDY.
REQ-028 Timeout expiry: when the counter reaches TIMEOUT_CLKS-1 without the awaited strobe, Timeout pulses for one cycle and the FSM returns to IDLE; Sample is unchanged.
REQ-029 Trigger in any state other than IDLE: the request is dropped, Overrun pulses the next cycle, and the FSM is unaffected.
REQ-030 EOC outside WAIT_EOC and DRDY outside WAIT_DRDY are ignored.
REQ-031 Strobe coincident with the last timeout cycle: the strobe wins; no Timeout is raised.
REQ-032 Trigger in the same cycle as DONE: the trigger is dropped with Overrun; there is no back-to-back acceptance.
REQ-033 Sample and SampleChan hold their values until the next successful read.

Reset
REQ-034 Reset forces state IDLE immediately (asynchronous); a conversion in progress is abandoned without Timeout.
REQ-035 Reset values: CONVST=0, DEN=0, DADDR=0, Sample=0, SampleChan=0, SampleValid=0, Overrun=0, Timeout=0; all counters are 0.

Structure
REQ-036 Shared package xadc_pkg contains the state enum, the 7-bit DRP address type, and the constants ADC_BITS=12 and CHAN_BITS=5.
REQ-037 Single module, no sub-modules; counter widths are derived with $clog2 of the parameters.

Verification
REQ-038 Trigger at t=10 with EOC 50 cycles after CONVST falls, Channel=3, and DRDY 2 cycles after DEN with DO=16'hABC0 -> CONVST high cycles 11-14, DEN one cycle with DADDR=7'h03, SampleValid one cycle with Sample=12'hABC and SampleChan=3.
REQ-039 Trigger while in WAIT_EOC -> Overrun pulses once and the first conversion completes normally.
REQ-040 No EOC after Trigger (TIMEOUT_CLKS=2000) -> Timeout pulses exactly 2000 cycles after WAIT_EOC entry, state returns to IDLE, and Sample is unchanged.
REQ-041 DEN issued and DRDY never returns -> Timeout pulses and the next Trigger is accepted normally.
REQ-042 Reset asserted mid-CONVST -> CONVST=0 asynchronously, no SampleValid, and the next Trigger after reset completes normally.
REQ-043 100 consecutive Triggers at the 10000-clock period -> 100 SampleValid pulses with zero Overrun and zero Timeout.

Source files
------------

// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC conversion reader.
package xadc_pkg;

  localparam int ADC_BITS  = 12;
  localparam int CHAN_BITS = 5;

  // Conversion sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    WAIT_EOC,
    READ,
    WAIT_DRDY,
    DONE
  } state_t;

  // DRP address as seen by the XADC primitive.
  typedef logic [6:0] drp_addr_t;

  // Status registers for channels sit at the channel number itself.
  function automatic drp_addr_t chan_to_daddr(input logic [CHAN_BITS-1:0] ch);
    return drp_addr_t'(ch);
  endfunction

endpackage

// File: rtl/xadc_reader.sv
// Drives one XADC conversion per accepted Trigger: pulses CONVST, waits for
// EOC, reads the channel result over DRP and presents the 12-bit sample.
// Requests arriving while busy are dropped and flagged; each wait is
// bounded so a missing strobe cannot hang the sequencer.
module xadc_reader
  import xadc_pkg::*;
#(
  parameter int CONVST_CLKS  = 4,
  parameter int TIMEOUT_CLKS = 2000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Trigger,
  input  logic                 EOC,
  input  logic [CHAN_BITS-1:0] Channel,
  input  logic                 DRDY,
  input  logic [15:0]          DO,
  output logic                 CONVST,
  output logic                 DEN,
  output logic                 DWE,
  output logic [6:0]           DADDR,
  output logic [ADC_BITS-1:0]  Sample,
  output logic [CHAN_BITS-1:0] SampleChan,
  output logic                 SampleValid,
  output logic                 Overrun,
  output logic                 Timeout
);

  localparam int CNV_W = $clog2(CONVST_CLKS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNV_W-1:0] CNV_LAST = CNV_W'(CONVST_CLKS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

  state_t                 state_reg, state_next;
  logic [CNV_W-1:0]       convst_cnt_reg, convst_cnt_next;
  logic [TMO_W-1:0]       tmo_cnt_reg, tmo_cnt_next;
  logic                   convst_reg;
  logic                   den_reg;
  drp_addr_t              daddr_reg, daddr_next;
  logic [ADC_BITS-1:0]    sample_reg, sample_next;
  logic [CHAN_BITS-1:0]   sample_chan_reg, sample_chan_next;
  logic                   sample_valid_reg;
  logic                   overrun_reg, overrun_next;
  logic                   timeout_reg, timeout_next;

  // The XADC result is left-justified; the low nibble carries no data.
  logic unused_do_bits;
  assign unused_do_bits = ^DO[15-ADC_BITS:0];

  // Next-state, counters and capture; every wait state carries its own timeout.
  always_comb begin
    state_next       = state_reg;
    convst_cnt_next  = '0;
    tmo_cnt_next     = '0;
    daddr_next       = daddr_reg;
    sample_next      = sample_reg;
    sample_chan_next = sample_chan_reg;
    timeout_next     = 1'b0;
    overrun_next     = Trigger && (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        if (Trigger) state_next = CONVERT;
      end
      CONVERT: begin
        if (convst_cnt_reg == CNV_LAST) state_next = WAIT_EOC;
        else convst_cnt_next = convst_cnt_reg + CNV_W'(1);
      end
      WAIT_EOC: begin
        // A strobe on the final allowed cycle still counts as success.
        if (EOC) begin
          daddr_next = chan_to_daddr(Channel);
          state_next = READ;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
        end
      end
      READ: begin
        state_next = WAIT_DRDY;
      end
      WAIT_DRDY: begin
        if (DRDY) begin
          sample_next      = DO[15 -: ADC_BITS];
          sample_chan_next = daddr_reg[CHAN_BITS-1:0];
          state_next       = DONE;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; outputs follow the state being entered.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg        <= IDLE;
      convst_cnt_reg   <= '0;
      tmo_cnt_reg      <= '0;
      convst_reg       <= 1'b0;
      den_reg          <= 1'b0;
      daddr_reg        <= '0;
      sample_reg       <= '0;
      sample_chan_reg  <= '0;
      sample_valid_reg <= 1'b0;
      overrun_reg      <= 1'b0;
      timeout_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      convst_cnt_reg   <= convst_cnt_next;
      tmo_cnt_reg      <= tmo_cnt_next;
      convst_reg       <= (state_next == CONVERT);
      den_reg          <= (state_next == READ);
      daddr_reg        <= daddr_next;
      sample_reg       <= sample_next;
      sample_chan_reg  <= sample_chan_next;
      sample_valid_reg <= (state_next == DONE);
      overrun_reg      <= overrun_next;
      timeout_reg      <= timeout_next;
    end
  end

  assign CONVST      = convst_reg;
  assign DEN         = den_reg;
  assign DWE         = 1'b0;
  assign DADDR       = daddr_reg;
  assign Sample      = sample_reg;
  assign SampleChan  = sample_chan_reg;
  assign SampleValid = sample_valid_reg;
  assign Overrun     = overrun_reg;
  assign Timeout     = timeout_reg;

endmodule

// File: tb/tb_xadc_reader.sv
// Directed bench for xadc_reader: a table of conversions with hand-computed
// results, plus sequences for overrun, timeouts and mid-conversion reset.
module tb_xadc_reader;

  localparam int C   = 4;
  localparam int TMO = 2000;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Trigger = 1'b0;
  logic        EOC = 1'b0;
  logic [4:0]  Channel = '0;
  logic        DRDY = 1'b0;
  logic [15:0] DO = '0;
  logic        CONVST, DEN, DWE;
  logic [6:0]  DADDR;
  logic [11:0] Sample;
  logic [4:0]  SampleChan;
  logic        SampleValid, Overrun, Timeout;

  int passed = 0;
  int total  = 0;
  int sv_count = 0;
  int ov_count = 0;
  int to_count = 0;

  xadc_reader #(.CONVST_CLKS(C), .TIMEOUT_CLKS(TMO)) dut (
    .Clk(Clk), .Reset(Reset), .Trigger(Trigger), .EOC(EOC), .Channel(Channel),
    .DRDY(DRDY), .DO(DO), .CONVST(CONVST), .DEN(DEN), .DWE(DWE), .DADDR(DADDR),
    .Sample(Sample), .SampleChan(SampleChan), .SampleValid(SampleValid),
    .Overrun(Overrun), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  // Count strobes once per cycle, on the edge that ends the cycle.
  always @(posedge Clk) begin
    if (SampleValid) sv_count++;
    if (Overrun)     ov_count++;
    if (Timeout)     to_count++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000 cycles");
    $fatal(1);
  end

  typedef struct {
    int          eoc_wait;
    logic [4:0]  chan;
    int          drdy_wait;
    logic [15:0] dval;
    logic [11:0] exp_sample;
    bit          trig_done;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // One full conversion; EOC comes eoc_wait cycles after CONVST falls and
  // DRDY comes drdy_wait cycles after the DEN cycle.
  task automatic conversion(input vec_t v, input string tag);
    int hi_cnt;
    hi_cnt = 0;
    @(negedge Clk); Trigger = 1'b1;
    @(negedge Clk); Trigger = 1'b0;
    for (int i = 0; i < C; i++) begin
      if (CONVST === 1'b1) hi_cnt++;
      @(negedge Clk);
    end
    check({tag, " convst_width"}, hi_cnt, C);
    check({tag, " convst_fall"}, CONVST, 1'b0);
    repeat (v.eoc_wait) @(negedge Clk);
    EOC = 1'b1; Channel = v.chan;
    @(negedge Clk); EOC = 1'b0; Channel = ~v.chan;
    check({tag, " den"}, DEN, 1'b1);
    check({tag, " daddr"}, DADDR, {2'b00, v.chan});
    @(negedge Clk);
    check({tag, " den_single"}, DEN, 1'b0);
    repeat (v.drdy_wait - 1) @(negedge Clk);
    DRDY = 1'b1; DO = v.dval;
    @(negedge Clk); DRDY = 1'b0; DO = ~v.dval;
    if (v.trig_done) Trigger = 1'b1;
    check({tag, " sample_valid"}, SampleValid, 1'b1);
    check({tag, " sample"}, Sample, v.exp_sample);
    check({tag, " sample_chan"}, SampleChan, v.chan);
    @(negedge Clk); Trigger = 1'b0;
    check({tag, " sample_valid_single"}, SampleValid, 1'b0);
    check({tag, " sample_hold"}, Sample, v.exp_sample);
    if (v.trig_done) begin
      check({tag, " overrun_in_done"}, Overrun, 1'b1);
      check({tag, " no_accept_in_done"}, CONVST, 1'b0);
    end
    $display("conversion %s: chan=%0d sample=0x%03h", tag, SampleChan, Sample);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t v;
    int   n, sv0, ov0, to0;
    logic [11:0] s0;

    vecs[0] = '{eoc_wait: 50,   chan: 5'd3,  drdy_wait: 2,    dval: 16'hABC0, exp_sample: 12'hABC, trig_done: 1'b0};
    vecs[1] = '{eoc_wait: 0,    chan: 5'd31, drdy_wait: 1,    dval: 16'hFFFF, exp_sample: 12'hFFF, trig_done: 1'b0};
    vecs[2] = '{eoc_wait: 1999, chan: 5'd16, drdy_wait: 2000, dval: 16'h0000, exp_sample: 12'h000, trig_done: 1'b0};
    vecs[3] = '{eoc_wait: 7,    chan: 5'd8,  drdy_wait: 5,    dval: 16'h123F, exp_sample: 12'h123, trig_done: 1'b1};
    vecs[4] = '{eoc_wait: 3,    chan: 5'd0,  drdy_wait: 3,    dval: 16'h8001, exp_sample: 12'h800, trig_done: 1'b0};

    // Reset values
    idle(2);
    check("reset CONVST", CONVST, 1'b0);
    check("reset DEN", DEN, 1'b0);
    check("reset DWE", DWE, 1'b0);
    check("reset DADDR", DADDR, 7'h00);
    check("reset Sample", Sample, 12'h000);
    check("reset SampleChan", SampleChan, 5'd0);
    check("reset SampleValid", SampleValid, 1'b0);
    check("reset Overrun", Overrun, 1'b0);
    check("reset Timeout", Timeout, 1'b0);
    $display("reset: outputs sampled while Reset high");
    Reset = 1'b0;
    idle(9);

    // Table of conversions, including strobes on the last timeout cycle
    ov0 = ov_count; to0 = to_count;
    for (int i = 0; i < 5; i++) begin
      conversion(vecs[i], $sformatf("vec%0d", i));
      idle(3);
    end
    idle(2);
    check("table no_timeout", to_count - to0, 0);
    check("table overrun_count", ov_count - ov0, 1);

    // Trigger while waiting for EOC
    ov0 = ov_count; sv0 = sv_count;
    @(negedge Clk); Trigger = 1'b1;
    @(negedge Clk); Trigger = 1'b0;
    repeat (C + 5) @(negedge Clk);
    Trigger = 1'b1;
    @(negedge Clk); Trigger = 1'b0;
    check("overrun_wait_eoc pulse", Overrun, 1'b1);
    @(negedge Clk);
    check("overrun_wait_eoc single", Overrun, 1'b0);
    EOC = 1'b1; Channel = 5'd9;
    @(negedge Clk); EOC = 1'b0;
    check("overrun_wait_eoc den", DEN, 1'b1);
    @(negedge Clk); DRDY = 1'b1; DO = 16'h5A5F;
    @(negedge Clk); DRDY = 1'b0;
    check("overrun_wait_eoc valid", SampleValid, 1'b1);
    check("overrun_wait_eoc sample", Sample, 12'h5A5);
    check("overrun_wait_eoc chan", SampleChan, 5'd9);
    idle(3);
    check("overrun_wait_eoc count", ov_count - ov0, 1);
    check("overrun_wait_eoc sv_count", sv_count - sv0, 1);
    $display("overrun in WAIT_EOC: sample=0x%03h", Sample);

    // EOC never arrives; stray EOC in CONVERT and DRDY in WAIT_EOC are ignored
    s0 = Sample; to0 = to_count;
    @(negedge Clk); Trigger = 1'b1;
    @(negedge Clk); Trigger = 1'b0; EOC = 1'b1; Channel = 5'd7;
    @(negedge Clk); EOC = 1'b0;
    repeat (C - 1) @(negedge Clk);
    DRDY = 1'b1;
    @(negedge Clk); DRDY = 1'b0;
    n = 1;
    while (Timeout !== 1'b1 && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    check("eoc_timeout latency", n, TMO);
    check("eoc_timeout sample", Sample, s0);
    @(negedge Clk);
    check("eoc_timeout single", Timeout, 1'b0);
    check("eoc_timeout convst", CONVST, 1'b0);
    idle(2);
    check("eoc_timeout count", to_count - to0, 1);
    $display("EOC timeout after %0d cycles", n);

    // DRDY never arrives after DEN
    s0 = Sample; to0 = to_count;
    @(negedge Clk); Trigger = 1'b1;
    @(negedge Clk); Trigger = 1'b0;
    repeat (C) @(negedge Clk);
    EOC = 1'b1; Channel = 5'd12;
    @(negedge Clk); EOC = 1'b0;
    check("drdy_timeout den", DEN, 1'b1);
    n = 0;
    while (Timeout !== 1'b1 && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    check("drdy_timeout latency", n, TMO + 1);
    check("drdy_timeout sample", Sample, s0);
    idle(2);
    check("drdy_timeout count", to_count - to0, 1);
    $display("DRDY timeout after %0d cycles", n);
    v = '{eoc_wait: 4, chan: 5'd12, drdy_wait: 2, dval: 16'h7E1A, exp_sample: 12'h7E1, trig_done: 1'b0};
    conversion(v, "after_drdy_timeout");
    idle(3);

    // Reset in the middle of CONVST
    sv0 = sv_count; to0 = to_count;
    @(negedge Clk); Trigger = 1'b1;
    @(negedge Clk); Trigger = 1'b0;
    check("reset_mid convst_before", CONVST, 1'b1);
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1 check("reset_mid convst_async", CONVST, 1'b0);
    @(negedge Clk); Reset = 1'b0;
    repeat (10) @(negedge Clk);
    EOC = 1'b1; Channel = 5'd2;
    @(negedge Clk); EOC = 1'b0;
    repeat (5) @(negedge Clk);
    DRDY = 1'b1; DO = 16'hFFF0;
    @(negedge Clk); DRDY = 1'b0;
    idle(10);
    check("reset_mid no_valid", sv_count - sv0, 0);
    check("reset_mid no_timeout", to_count - to0, 0);
    check("reset_mid sample_cleared", Sample, 12'h000);
    $display("reset mid-CONVST: CONVST=%0b Sample=0x%03h", CONVST, Sample);
    v = '{eoc_wait: 10, chan: 5'd21, drdy_wait: 2, dval: 16'h3C3C, exp_sample: 12'h3C3, trig_done: 1'b0};
    conversion(v, "after_reset");
    idle(3);

    // Periodic triggers, compressed period so the run stays short
    sv0 = sv_count; ov0 = ov_count; to0 = to_count;
    for (int k = 0; k < 20; k++) begin
      v.eoc_wait   = 10 + k;
      v.chan       = 5'(k);
      v.drdy_wait  = 2;
      v.dval       = {4'(k), 8'hA5, 4'h0};
      v.exp_sample = {4'(k), 8'hA5};
      v.trig_done  = 1'b0;
      conversion(v, $sformatf("periodic%0d", k));
      idle(100);
    end
    check("periodic valid_count", sv_count - sv0, 20);
    check("periodic overrun_count", ov_count - ov0, 0);
    check("periodic timeout_count", to_count - to0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
